vpifo_root_scheduler: RTL and testbench

//  Front-end stage directly upstream of the level-0 PIFO_SRAM node of the virtual PIFO tree.

---
 rtl/vpifo_root_scheduler.sv | 168 ++++++++++++++++
 tb/tb_vpifo_root_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vpifo_root_scheduler.sv
// Root scheduler in front of the level-0 PIFO_SRAM node.
// Arbitrates push/pop per slot, tracks tree counts, returns pops.
//
// Ports:
//   i_clk, i_arst_n            clock, async active-low reset
//   s_push_*                   push request (valid/ready, tree, data)
//   s_pop_*                    pop request (valid/ready, tree)
//   m_pop_*                    pop result (valid pulse, data, tree, empty)
//   o_push_drop                accepted push discarded, tree full
//   o_push/o_pop/o_push_data   registered commands to level-0 node
//   o_tree_id                  tree id of issued command
//   i_pop_data                 level-0 node pop data
//   o_my_addr/o_level          node identity, tied to 0
//   o_occupancy                per-tree counts, tree k at [k*CNW +: CNW]
module vpifo_root_scheduler #(
  parameter int PTW      = 16,
  parameter int MTW      = 0,
  parameter int LEVEL    = 4,
  parameter int TREE_NUM = 4,
  parameter int TREE_CAP = 2 * ((1 << LEVEL) - 1),
  localparam int DW  = MTW + PTW,
  localparam int TW  = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
  localparam int CNW = $clog2(TREE_CAP + 1),
  localparam int LW  = (LEVEL > 1) ? $clog2(LEVEL) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic                    s_push_valid,
  output logic                    s_push_ready,
  input  logic [TW-1:0]           s_push_tree,
  input  logic [DW-1:0]           s_push_data,
  input  logic                    s_pop_valid,
  output logic                    s_pop_ready,
  input  logic [TW-1:0]           s_pop_tree,
  output logic                    m_pop_valid,
  output logic [DW-1:0]           m_pop_data,
  output logic [TW-1:0]           m_pop_tree,
  output logic                    m_pop_empty,
  output logic                    o_push_drop,
  output logic                    o_push,
  output logic                    o_pop,
  output logic [DW-1:0]           o_push_data,
  input  logic [DW-1:0]           i_pop_data,
  output logic [TW-1:0]           o_tree_id,
  output logic [LEVEL-2:0]        o_my_addr,
  output logic [LW-1:0]           o_level,
  output logic [TREE_NUM*CNW-1:0] o_occupancy
);

  localparam logic [CNW-1:0] CAP = CNW'(TREE_CAP);
  localparam logic [CNW-1:0] ONE = CNW'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  typedef struct packed {
    logic          v;
    logic          e;
    logic [TW-1:0] tree;
  } pop_pipe_t;

  state_t         state_q;
  state_t         state_d;
  logic           prefer_pop;
  logic [CNW-1:0] cnt_q [TREE_NUM];
  pop_pipe_t      p1_q;
  pop_pipe_t      p2_q;

  logic           push_hs;
  logic           pop_hs;
  logic [CNW-1:0] push_cnt;
  logic [CNW-1:0] pop_cnt;
  logic           push_full;
  logic           pop_empty;

  assign o_my_addr = '0;
  assign o_level   = '0;

  assign push_cnt  = cnt_q[s_push_tree];
  assign pop_cnt   = cnt_q[s_pop_tree];
  assign push_full = (push_cnt == CAP);
  assign pop_empty = (pop_cnt == '0);
  assign push_hs   = s_push_valid & s_push_ready;
  assign pop_hs    = s_pop_valid & s_pop_ready;

  // Readies are gated by reset so nothing is granted while held.
  always_comb begin
    state_d      = state_q;
    s_pop_ready  = 1'b0;
    s_push_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        s_pop_ready  = i_arst_n & (~s_push_valid | prefer_pop);
        s_push_ready = i_arst_n & (~s_pop_valid | ~prefer_pop);
        if (pop_hs) state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_occupancy = '0;
    for (int k = 0; k < TREE_NUM; k++) begin
      o_occupancy[k*CNW +: CNW] = cnt_q[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= S_IDLE;
      prefer_pop  <= 1'b1;
      for (int k = 0; k < TREE_NUM; k++) cnt_q[k] <= '0;
      o_push      <= 1'b0;
      o_pop       <= 1'b0;
      o_push_data <= '0;
      o_tree_id   <= '0;
      o_push_drop <= 1'b0;
      p1_q        <= '0;
      p2_q        <= '0;
      m_pop_valid <= 1'b0;
      m_pop_empty <= 1'b0;
      m_pop_tree  <= '0;
      m_pop_data  <= '0;
    end else begin
      state_q     <= state_d;
      o_push      <= 1'b0;
      o_pop       <= 1'b0;
      o_push_data <= '0;
      o_tree_id   <= '0;
      o_push_drop <= 1'b0;
      if (push_hs) begin
        prefer_pop <= 1'b1;
        if (push_full) begin
          o_push_drop <= 1'b1;
        end else begin
          o_push             <= 1'b1;
          o_push_data        <= s_push_data;
          o_tree_id          <= s_push_tree;
          cnt_q[s_push_tree] <= push_cnt + ONE;
        end
      end
      if (pop_hs) begin
        prefer_pop <= 1'b0;
        if (!pop_empty) begin
          o_pop             <= 1'b1;
          o_tree_id         <= s_pop_tree;
          cnt_q[s_pop_tree] <= pop_cnt - ONE;
        end
      end
      // Result pipe: node answers in the cycle after o_pop.
      p1_q.v    <= pop_hs;
      p1_q.e    <= pop_hs & pop_empty;
      p1_q.tree <= pop_hs ? s_pop_tree : '0;
      p2_q      <= p1_q;
      m_pop_valid <= p2_q.v;
      m_pop_empty <= p2_q.v & p2_q.e;
      m_pop_tree  <= p2_q.v ? p2_q.tree : '0;
      if (!p2_q.v) m_pop_data <= '0;
      else if (p2_q.e) m_pop_data <= '1;
      else m_pop_data <= i_pop_data;
    end
  end

endmodule

// File: tb/tb_vpifo_root_scheduler.sv
// Randomized bench for vpifo_root_scheduler against a cycle model.
// Model tracks tree counts and schedules expected outputs by cycle.
module tb_vpifo_root_scheduler;

  localparam int N   = 4096;
  localparam int CAP = 30;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic        s_push_valid;
  logic        s_push_ready;
  logic [1:0]  s_push_tree;
  logic [15:0] s_push_data;
  logic        s_pop_valid;
  logic        s_pop_ready;
  logic [1:0]  s_pop_tree;
  logic        m_pop_valid;
  logic [15:0] m_pop_data;
  logic [1:0]  m_pop_tree;
  logic        m_pop_empty;
  logic        o_push_drop;
  logic        o_push;
  logic        o_pop;
  logic [15:0] o_push_data;
  logic [15:0] i_pop_data;
  logic [1:0]  o_tree_id;
  logic [2:0]  o_my_addr;
  logic [1:0]  o_level;
  logic [19:0] o_occupancy;

  vpifo_root_scheduler dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n),
    .s_push_valid(s_push_valid), .s_push_ready(s_push_ready),
    .s_push_tree(s_push_tree), .s_push_data(s_push_data),
    .s_pop_valid(s_pop_valid), .s_pop_ready(s_pop_ready),
    .s_pop_tree(s_pop_tree),
    .m_pop_valid(m_pop_valid), .m_pop_data(m_pop_data),
    .m_pop_tree(m_pop_tree), .m_pop_empty(m_pop_empty),
    .o_push_drop(o_push_drop), .o_push(o_push), .o_pop(o_pop),
    .o_push_data(o_push_data), .i_pop_data(i_pop_data),
    .o_tree_id(o_tree_id), .o_my_addr(o_my_addr),
    .o_level(o_level), .o_occupancy(o_occupancy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        e_push [N];
  logic        e_pop  [N];
  logic        e_drop [N];
  logic [15:0] e_pd   [N];
  logic [1:0]  e_tid  [N];
  logic        e_mv   [N];
  logic        e_me   [N];
  logic [1:0]  e_mt   [N];
  logic [15:0] pdat   [N];

  int cnt [4];
  bit pp;
  bit gap;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [19:0] occ_exp();
    logic [19:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*5 +: 5] = 5'(cnt[k]);
    return v;
  endfunction

  task automatic clear_from(input int c);
    for (int i = c; i < N; i++) begin
      e_push[i] = 0; e_pop[i] = 0; e_drop[i] = 0;
      e_pd[i] = '0; e_tid[i] = '0;
      e_mv[i] = 0; e_me[i] = 0; e_mt[i] = '0; pdat[i] = '0;
    end
  endtask

  task automatic check_outputs();
    logic [15:0] md;
    md = !e_mv[cyc] ? 16'h0 : e_me[cyc] ? 16'hFFFF : pdat[cyc-1];
    chk("o_push", o_push, e_push[cyc]);
    chk("o_pop", o_pop, e_pop[cyc]);
    chk("o_push_drop", o_push_drop, e_drop[cyc]);
    chk("o_push_data", o_push_data, e_pd[cyc]);
    chk("o_tree_id", o_tree_id, e_tid[cyc]);
    chk("m_pop_valid", m_pop_valid, e_mv[cyc]);
    chk("m_pop_empty", m_pop_empty, e_me[cyc]);
    chk("m_pop_tree", m_pop_tree, e_mt[cyc]);
    chk("m_pop_data", m_pop_data, md);
    chk("occupancy", o_occupancy, occ_exp());
    chk("id", {o_my_addr, o_level}, 32'h0);
  endtask

  task automatic step(input logic pv, input logic [1:0] pt,
                      input logic [15:0] pd, input logic qv,
                      input logic [1:0] qt);
    logic pr, qr, pg, qg;
    check_outputs();
    s_push_valid = pv;
    s_push_tree  = pt;
    s_push_data  = pd;
    s_pop_valid  = qv;
    s_pop_tree   = qt;
    pdat[cyc]    = 16'($urandom);
    i_pop_data   = pdat[cyc];
    #1;
    pr = !gap && (!qv || !pp);
    qr = !gap && (!pv || pp);
    chk("push_ready", s_push_ready, pr);
    chk("pop_ready", s_pop_ready, qr);
    pg = pv && pr;
    qg = qv && qr;
    if (pg) begin
      pp = 1;
      if (cnt[pt] == CAP) begin
        e_drop[cyc+1] = 1;
      end else begin
        e_push[cyc+1] = 1;
        e_pd[cyc+1]   = pd;
        e_tid[cyc+1]  = pt;
        cnt[pt]++;
      end
    end
    if (qg) begin
      pp = 0;
      e_mv[cyc+3] = 1;
      e_mt[cyc+3] = qt;
      if (cnt[qt] == 0) begin
        e_me[cyc+3] = 1;
      end else begin
        e_pop[cyc+1] = 1;
        e_tid[cyc+1] = qt;
        cnt[qt]--;
      end
    end
    gap = qg;
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_arst_n     = 1'b0;
    s_push_valid = 0;
    s_pop_valid  = 0;
    #1;
    chk("rst_push", o_push, 0);
    chk("rst_pop", o_pop, 0);
    chk("rst_mv", m_pop_valid, 0);
    chk("rst_drop", o_push_drop, 0);
    chk("rst_occ", o_occupancy, 0);
    chk("rst_ready", {s_push_ready, s_pop_ready}, 0);
    clear_from(cyc);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    pp  = 1;
    gap = 0;
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    i_arst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    logic pv, qv;
    int   pprob, qprob;
    i_arst_n     = 1'b0;
    s_push_valid = 0;
    s_push_tree  = 0;
    s_push_data  = 0;
    s_pop_valid  = 0;
    s_pop_tree   = 0;
    i_pop_data   = 0;
    clear_from(0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    do_reset();

    step(1, 1, 16'h0005, 0, 0);
    step(1, 1, 16'h0003, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 1);
    idle(4);
    for (int i = 0; i < 8; i++) step(1, 0, 16'(i), 1, 0);
    idle(4);
    for (int i = 0; i < CAP + 2; i++) step(1, 2, 16'(100 + i), 0, 0);
    idle(2);
    step(0, 0, 0, 1, 3);
    idle(4);
    step(0, 0, 0, 1, 2);
    chk("pre_rst_pop", o_pop, e_pop[cyc]);
    do_reset();
    idle(6);

    for (int i = 0; i < 1500; i++) begin
      unique case ((i / 150) % 3)
        0: begin pprob = 80; qprob = 20; end
        1: begin pprob = 50; qprob = 50; end
        default: begin pprob = 20; qprob = 80; end
      endcase
      pv = ($urandom_range(0, 99) < pprob);
      qv = ($urandom_range(0, 99) < qprob);
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(pv, 2'($urandom), 16'($urandom), qv, 2'($urandom));
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
